// File: rtl/cache_2way_wb.sv
// 2-way set-associative write-back/write-allocate cache, one word per line, LRU per set.
// Misses evict dirty victims (WB) before filling (FILL); both memory phases last MEMLAT cycles.
module cache_2way_wb #(
  parameter int NBITS  = 8,
  parameter int NA     = 6,
  parameter int SA     = 4,
  parameter int MEMLAT = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NA-1:0]    Address,
  input  logic [NBITS-1:0] WriteData,
  output logic [NBITS-1:0] ReadData,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic             busy,
  output logic [NA-1:0]    memAddress,
  output logic [NBITS-1:0] memWriteData,
  input  logic [NBITS-1:0] memReadData,
  output logic             memMemRead,
  output logic             memMemWrite
);
  localparam int NS = 1 << SA;
  localparam int TW = NA - SA;
  localparam int CW = $clog2(MEMLAT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEMLAT - 1);

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NS-1:0][1:0][NBITS-1:0] data_q;
  logic [NS-1:0][1:0][TW-1:0]    tag_q;
  logic [NS-1:0][1:0]            valid_q, dirty_q;
  logic [NS-1:0]                 lru_q;

  logic [NA-1:0]    miss_addr_q, miss_addr_d;
  logic             victim_q, victim_d;
  logic [NA-1:0]    mem_addr_d;
  logic [NBITS-1:0] mem_wdata_d;
  logic             mem_rd_d, mem_wr_d, fill_done;

  logic [SA-1:0] set;
  logic [TW-1:0] tag;
  logic [1:0]    hit_w;
  logic          hit, hitway, req, vsel;

  assign set = Address[SA-1:0];
  assign tag = Address[NA-1:SA];

  for (genvar w = 0; w < 2; w++) begin : g_way
    assign hit_w[w] = valid_q[set][w] && (tag_q[set][w] == tag);
  end

  assign hit      = |hit_w;
  assign hitway   = hit_w[1];
  assign req      = MemRead | MemWrite;
  assign busy     = req && !(state_q == IDLE && hit);
  assign ReadData = hit ? data_q[set][hitway] : '0;
  // Invalid ways fill first (way 0 preferred); otherwise evict the LRU way.
  assign vsel     = !valid_q[set][0] ? 1'b0 : (!valid_q[set][1] ? 1'b1 : lru_q[set]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    miss_addr_d = miss_addr_q;
    victim_d    = victim_q;
    mem_addr_d  = memAddress;
    mem_wdata_d = memWriteData;
    mem_rd_d    = memMemRead;
    mem_wr_d    = memMemWrite;
    fill_done   = 1'b0;
    case (state_q)
      IDLE: if (req && !hit) begin
        miss_addr_d = Address;
        victim_d    = vsel;
        cnt_d       = '0;
        if (valid_q[set][vsel] && dirty_q[set][vsel]) begin
          state_d     = WB;
          mem_addr_d  = {tag_q[set][vsel], set};
          mem_wdata_d = data_q[set][vsel];
          mem_wr_d    = 1'b1;
        end else begin
          state_d    = FILL;
          mem_addr_d = Address;
          mem_rd_d   = 1'b1;
        end
      end
      WB: if (cnt_q == LAST) begin
        state_d    = FILL;
        cnt_d      = '0;
        mem_wr_d   = 1'b0;
        mem_rd_d   = 1'b1;
        mem_addr_d = miss_addr_q;
      end else cnt_d = cnt_q + 1'b1;
      FILL: if (cnt_q == LAST) begin
        state_d   = IDLE;
        cnt_d     = '0;
        mem_rd_d  = 1'b0;
        fill_done = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      miss_addr_q  <= '0;
      victim_q     <= 1'b0;
      memAddress   <= '0;
      memWriteData <= '0;
      memMemRead   <= 1'b0;
      memMemWrite  <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
      lru_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      miss_addr_q  <= miss_addr_d;
      victim_q     <= victim_d;
      memAddress   <= mem_addr_d;
      memWriteData <= mem_wdata_d;
      memMemRead   <= mem_rd_d;
      memMemWrite  <= mem_wr_d;
      if (state_q == IDLE && req && hit) begin
        lru_q[set] <= ~hitway;
        if (MemWrite) dirty_q[set][hitway] <= 1'b1;
      end
      if (fill_done) begin
        valid_q[miss_addr_q[SA-1:0]][victim_q] <= 1'b1;
        dirty_q[miss_addr_q[SA-1:0]][victim_q] <= 1'b0;
      end
    end
  end

  // Data and tag arrays carry no reset; valid bits guard them.
  always_ff @(posedge clock) begin
    if (state_q == IDLE && MemWrite && hit) data_q[set][hitway] <= WriteData;
    if (fill_done) begin
      data_q[miss_addr_q[SA-1:0]][victim_q] <= memReadData;
      tag_q[miss_addr_q[SA-1:0]][victim_q]  <= miss_addr_q[NA-1:SA];
    end
  end
endmodule

// File: tb/tb_cache_2way_wb.sv
// Directed bench for cache_2way_wb: memory model returns addr^0xA0 unless written back.
module tb_cache_2way_wb;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Address = '0;
  logic [7:0] WriteData = '0;
  logic [7:0] ReadData;
  logic       MemRead = 1'b0, MemWrite = 1'b0;
  logic       busy;
  logic [5:0] memAddress;
  logic [7:0] memWriteData, memReadData;
  logic       memMemRead, memMemWrite;

  cache_2way_wb #(.NBITS(8), .NA(6), .SA(4), .MEMLAT(3)) dut (
    .clock(clock), .reset(reset), .Address(Address), .WriteData(WriteData),
    .ReadData(ReadData), .MemRead(MemRead), .MemWrite(MemWrite), .busy(busy),
    .memAddress(memAddress), .memWriteData(memWriteData), .memReadData(memReadData),
    .memMemRead(memMemRead), .memMemWrite(memMemWrite)
  );

  always #5 clock = ~clock;

  int ntests = 0, nfail = 0;
  int rd_cyc = 0, wr_cyc = 0, overlap = 0;
  logic [5:0] rd_addr = '0, wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] wmem [64];
  logic [63:0] wvld = '0;

  assign memReadData = wvld[memAddress] ? wmem[memAddress] : ({2'b00, memAddress} ^ 8'hA0);

  // Strobes sampled mid-cycle; written-back words override the default pattern.
  always @(negedge clock) begin
    if (memMemRead) begin rd_cyc++; rd_addr = memAddress; end
    if (memMemWrite) begin
      wr_cyc++; wr_addr = memAddress; wr_data = memWriteData;
      wmem[memAddress] = memWriteData; wvld[memAddress] = 1'b1;
    end
    if (memMemRead && memMemWrite) overlap++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    ntests++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    MemRead = 0; MemWrite = 0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Holds a request until busy drops, returns busy-cycle count, final and first-cycle ReadData.
  task automatic do_req(input bit we, input logic [5:0] a, input logic [7:0] wd,
                        output int nb, output logic [7:0] rd, output logic [7:0] rd0);
    Address = a; WriteData = wd; MemWrite = we; MemRead = !we; nb = 0;
    #1;
    rd0 = ReadData;
    while (busy && nb < 50) begin nb++; @(posedge clock); #1; end
    if (nb >= 50) chk("busy_timeout", nb, 0);
    rd = ReadData;
    @(posedge clock); #1;
    MemRead = 0; MemWrite = 0;
  endtask

  initial begin
    int nb, r0, w0;
    logic [7:0] rd, rd0;

    // Reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_mrd", memMemRead, 0);
    chk("rst_mwr", memMemWrite, 0);
    chk("rst_maddr", memAddress, 0);
    chk("rst_mwdata", memWriteData, 0);
    apply_reset();

    // 1: clean read miss then hit
    r0 = rd_cyc;
    do_req(0, 6'h05, 8'h00, nb, rd, rd0);
    chk("t1_busy", nb, 4);
    chk("t1_miss_rdata", rd0, 0);
    chk("t1_rd_cycles", rd_cyc - r0, 3);
    chk("t1_rd_addr", rd_addr, 6'h05);
    chk("t1_rdata", rd, 8'hA5);
    do_req(0, 6'h05, 8'h00, nb, rd, rd0);
    chk("t1_hit_busy", nb, 0);
    chk("t1_hit_rdata", rd, 8'hA5);

    // 2: write hit, no stall, no traffic
    r0 = rd_cyc; w0 = wr_cyc;
    do_req(1, 6'h05, 8'h3C, nb, rd, rd0);
    chk("t2_busy", nb, 0);
    chk("t2_traffic", (rd_cyc - r0) + (wr_cyc - w0), 0);
    do_req(0, 6'h05, 8'h00, nb, rd, rd0);
    chk("t2_rdata", rd, 8'h3C);

    // 3: LRU picks the clean way 1 victim
    apply_reset();
    do_req(0, 6'h05, 8'h00, nb, rd, rd0);
    do_req(0, 6'h15, 8'h00, nb, rd, rd0);
    chk("t3_fill15", rd, 8'hB5);
    do_req(0, 6'h05, 8'h00, nb, rd, rd0);
    chk("t3_hit05", nb, 0);
    w0 = wr_cyc;
    do_req(0, 6'h25, 8'h00, nb, rd, rd0);
    chk("t3_busy25", nb, 4);
    chk("t3_no_wb", wr_cyc - w0, 0);
    chk("t3_rdata25", rd, 8'h85);
    do_req(0, 6'h05, 8'h00, nb, rd, rd0);
    chk("t3_still05", nb, 0);
    do_req(0, 6'h15, 8'h00, nb, rd, rd0);
    chk("t3_miss15", nb, 4);

    // 4: dirty eviction of 0x05 when 0x25 fills
    do_req(1, 6'h05, 8'h5A, nb, rd, rd0);
    chk("t4_whit", nb, 0);
    do_req(0, 6'h15, 8'h00, nb, rd, rd0);
    chk("t4_hit15", nb, 0);
    r0 = rd_cyc; w0 = wr_cyc;
    do_req(0, 6'h25, 8'h00, nb, rd, rd0);
    chk("t4_busy", nb, 7);
    chk("t4_wr_cycles", wr_cyc - w0, 3);
    chk("t4_wr_addr", wr_addr, 6'h05);
    chk("t4_wr_data", wr_data, 8'h5A);
    chk("t4_rd_cycles", rd_cyc - r0, 3);
    chk("t4_rd_addr", rd_addr, 6'h25);
    chk("t4_rdata", rd, 8'h85);
    chk("t4_overlap", overlap, 0);

    // 5: write miss allocates, later evicted back
    apply_reset();
    r0 = rd_cyc; w0 = wr_cyc;
    do_req(1, 6'h0A, 8'h77, nb, rd, rd0);
    chk("t5_busy", nb, 4);
    chk("t5_rd_cycles", rd_cyc - r0, 3);
    chk("t5_no_wb", wr_cyc - w0, 0);
    do_req(0, 6'h0A, 8'h00, nb, rd, rd0);
    chk("t5_rdata", rd, 8'h77);
    chk("t5_rhit", nb, 0);
    do_req(0, 6'h1A, 8'h00, nb, rd, rd0);
    w0 = wr_cyc;
    do_req(0, 6'h2A, 8'h00, nb, rd, rd0);
    chk("t5_evict_busy", nb, 7);
    chk("t5_evict_cycles", wr_cyc - w0, 3);
    chk("t5_evict_addr", wr_addr, 6'h0A);
    chk("t5_evict_data", wr_data, 8'h77);

    // 6: reset during FILL cycle 2
    apply_reset();
    Address = 6'h33; MemRead = 1'b1;
    #1;
    chk("t6_busy0", busy, 1);
    @(posedge clock); #1;
    chk("t6_fill_c1", memMemRead, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("t6_strobe_drop", memMemRead, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    do_req(0, 6'h33, 8'h00, nb, rd, rd0);
    chk("t6_busy_again", nb, 4);
    chk("t6_rdata", rd, 8'h93);
    chk("overlap_total", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/cache_2way_wb.md
# cache_2way_wb

Parametrised successor to the direct-mapped write-through cache. It sits between the processor's load/store port and a fixed-latency word memory. It is 2-way set-associative, write-back/write-allocate, with per-set LRU replacement, dirty-line eviction and a configurable memory latency. The processor interface is unchanged except that write hits now complete without stalling.

## Interface
- NBITS, 8, data word width
- NA, 6, memory address width
- SA, 4, set-index width; 2**SA sets × 2 ways, 1 word per line; tag width NA-SA (≥1)
- MEMLAT, 3, memory access length in cycles (≥1)

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- Address  in  NA  processor address, {tag, set}
- WriteData  in  NBITS  processor store data
- ReadData  out  NBITS  load data from the hitting way; 0 when no hit
- MemRead  in  1  load request
- MemWrite  in  1  store request; takes priority if both requests are high
- busy  out  1  request not yet satisfied; processor holds all inputs stable while high
- memAddress  out  NA  memory address (registered)
- memWriteData  out  NBITS  eviction data (registered)
- memReadData  in  NBITS  memory data, valid in the last cycle of a read access
- memMemRead  out  1  memory read strobe (registered)
- memMemWrite  out  1  memory write strobe (registered)

## Operation
- Per set and way: data, tag, valid, dirty. Per set: one lru bit, which names the least-recently-used way.
- Hit = valid && tag match in way 0 or way 1. Both ways never hold the same tag.
- busy = (MemRead|MemWrite) && !(state==IDLE && hit). This is combinational.
- Read hit in IDLE: ReadData = hit-way data in the same cycle. lru[set] <= ~hitway.
- Write hit in IDLE: hit-way data <= WriteData and dirty <= 1 at the edge. lru updated. No memory traffic.
- Miss in IDLE picks a victim way:
  - the first invalid way, way 0 preferred;
  - otherwise way lru[set].
- If the victim is valid and dirty, go to WB:
  - memAddress = {victimTag, set}, memWriteData = victim data, memMemWrite = 1;
  - held for MEMLAT cycles, then go to FILL.
- Otherwise go straight to FILL.
- FILL: memAddress = Address, memMemRead = 1, held for MEMLAT cycles.
  - At the edge ending the last cycle, the victim way gets data = memReadData, tag, valid = 1, dirty = 0.
  - Strobes drop and state returns to IDLE.
- Back in IDLE, the held request re-evaluates as a hit. A write then sets dirty; no separate write path exists.
- States: IDLE, WB, FILL. A counter runs 0..MEMLAT-1 inside WB and FILL and is cleared on each entry.
- Requests dropped mid-miss do not abort the miss; the fill completes regardless.

## Timing
- Reset (async) values:
  - state IDLE, counter 0;
  - valid, dirty and lru all 0;
  - memAddress 0, memWriteData 0, memMemRead 0, memMemWrite 0.
- Data and tag arrays are not reset.
- busy follows the inputs combinationally during reset.
- Hit latency: 0 cycles stall.
- Clean miss: busy high for MEMLAT+1 cycles.
- Dirty miss: busy high for 2·MEMLAT+1 cycles.
- Strobes rise on the edge leaving IDLE or WB and are high for exactly MEMLAT cycles each. They are never high together.
- Reset mid-WB or mid-FILL: strobes drop immediately. The line is not installed and evicted dirty data is lost.

## Test plan
1. Reset, then read 0x05 with memory returning 0xA5.
   - busy is high 4 cycles; memMemRead is high cycles 1–3 with memAddress 0x05.
   - Cycle 4: ReadData = 0xA5, busy = 0. A repeat read hits with busy = 0.
2. After test 1, write 0x3C to 0x05.
   - busy = 0 and no strobes. A read of 0x05 returns 0x3C.
3. Fill 0x05 (way 0) and 0x15 (way 1), then read 0x05, then read 0x25.
   - 0x15 is evicted (clean) with no memMemWrite.
   - 0x05 still hits; 0x15 now misses.
4. Write 0x5A to 0x05 (dirty), read 0x15 (0x05 becomes LRU), then read 0x25.
   - memMemWrite for 3 cycles: addr 0x05, data 0x5A.
   - Then memMemRead for 3 cycles: addr 0x25.
   - busy is high 7 cycles.
5. From empty, write 0x77 to 0x0A.
   - busy for 4 cycles, a read fill and no memMemWrite.
   - A later read returns 0x77; a later eviction writes 0x77 back.
6. Assert reset in FILL cycle 2.
   - memMemRead falls the same cycle.
   - After release, a read of the same address misses again with the full 4-cycle busy.
